// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 bit voting and
// a first-word fall-through byte FIFO on the output side.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx,
    output logic [7:0]                        data_out,
    output logic                              valid,
    input  logic                              ready,
    output logic                              frame_err,
    output logic                              overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            meta_q, rxs_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      sc_q, sc_d;
    logic            s7_q, s7_d, s8_q, s8_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_q, bit_d;
    logic            tick, active, dec, eob, maj;
    logic            push_req;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q, count_d;
    logic            full, push, pop;

    assign tick   = (presc_q == PW'(DIV - 1));
    assign active = (state_q == START) || (state_q == DATA)
                 || (state_q == STOP);
    assign dec    = active && tick && (sc_q == 4'd9);
    assign eob    = active && tick && (sc_q == 4'd15);
    assign maj    = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

    always_comb begin
        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        sc_d      = sc_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        push_req  = 1'b0;
        frame_err = 1'b0;
        if (active && tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == 4'd7) s7_d = rxs_q;
            if (sc_q == 4'd8) s8_d = rxs_q;
        end
        unique case (state_q)
            IDLE: begin
                // Realign bit timing to the start edge.
                if (!rxs_q) begin
                    state_d = START;
                    presc_d = '0;
                    sc_d    = '0;
                end
            end
            START: begin
                if (dec && maj) begin
                    state_d = IDLE;
                end else if (eob) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (dec) shift_d = {maj, shift_q[7:1]};
                if (eob) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else bit_d = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (dec) begin
                    if (maj) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            meta_q  <= 1'b1;
            rxs_q   <= 1'b1;
            presc_q <= '0;
            sc_q    <= '0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            meta_q  <= rx;
            rxs_q   <= meta_q;
            presc_q <= presc_d;
            sc_q    <= sc_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign valid   = (count_q != '0);
    assign pop     = valid && ready;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign push    = push_req && (!full || pop);
    assign overrun = push_req && full && !pop;
    assign data_out   = valid ? mem[rd_q] : 8'h00;
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clk per bit (DIV=1).
module tb_uart_rx_fifo;

    localparam int CF = 1_600_000;
    localparam int BR = 100_000;
    localparam int FD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic [4:0] fifo_count;

    uart_rx_fifo #(
        .CLK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data_out(data_out), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] popq[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vhigh_cnt = 0;
    int vrise_cyc = -1;
    logic valid_prev = 1'b0;
    int t0;
    int n_chk = 0;
    int n_pass = 0;

    always @(negedge clk) begin
        if (valid && ready) popq.push_back(data_out);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (valid) vhigh_cnt++;
        if (valid && !valid_prev) vrise_cyc = cyc;
        valid_prev = valid;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        popq.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        vhigh_cnt = 0;
        vrise_cyc = -1;
    endtask

    // Starts at posedge+1; returns 160 clocks later for a normal stop.
    task automatic send(input logic [7:0] b, input int stop_low,
                        input bit pop_at_push);
        t0 = cyc;
        rx = 1'b0;
        clks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(16);
        end
        if (pop_at_push) begin
            rx = 1'b1;
            clks(12);
            ready = 1'b1;
            clks(1);
            ready = 1'b0;
            clks(3);
        end else if (stop_low > 0) begin
            rx = 1'b0;
            clks(stop_low);
            rx = 1'b1;
            clks(16);
        end else begin
            rx = 1'b1;
            clks(16);
        end
    endtask

    initial begin
        clks(3);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        rst = 1'b0;
        clks(5);

        // Single byte, immediate consume
        clr();
        ready = 1'b1;
        send(8'hA5, 0, 1'b0);
        clks(5);
        chk("a5_n", 32'(popq.size()), 32'd1);
        chk("a5_data", (popq.size() > 0) ? 32'(popq[0]) : 32'hDEAD,
            32'hA5);
        chk("a5_lat", 32'(vrise_cyc - t0), 32'd157);
        chk("a5_vcyc", 32'(vhigh_cnt), 32'd1);
        chk("a5_count", 32'(fifo_count), 32'd0);
        chk("a5_ferr", 32'(fe_cnt), 32'd0);

        // Glitch shorter than a half bit
        clr();
        rx = 1'b0;
        clks(6);
        rx = 1'b1;
        clks(40);
        chk("glitch_v", 32'(vhigh_cnt), 32'd0);
        chk("glitch_fe", 32'(fe_cnt), 32'd0);
        chk("glitch_cnt", 32'(fifo_count), 32'd0);
        send(8'h5A, 0, 1'b0);
        clks(5);
        chk("glitch_next", (popq.size() == 1) ? 32'(popq[0]) : 32'hDEAD,
            32'h5A);

        // Framing error then recovery
        clr();
        send(8'h3C, 40, 1'b0);
        clks(4);
        chk("fe_pulse", 32'(fe_cnt), 32'd1);
        chk("fe_count", 32'(fifo_count), 32'd0);
        chk("fe_nopush", 32'(popq.size()), 32'd0);
        send(8'h55, 0, 1'b0);
        clks(5);
        chk("fe_next", (popq.size() == 1) ? 32'(popq[0]) : 32'hDEAD,
            32'h55);
        chk("fe_once", 32'(fe_cnt), 32'd1);

        // Fill to full, then overrun
        clr();
        ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0);
        chk("full_cnt", 32'(fifo_count), 32'd16);
        chk("full_noovr", 32'(ov_cnt), 32'd0);
        send(8'h10, 0, 1'b0);
        chk("ovr_cnt", 32'(fifo_count), 32'd16);
        chk("ovr_pulse", 32'(ov_cnt), 32'd1);
        chk("ovr_head", 32'(data_out), 32'h00);

        // Push and pop together while full
        send(8'h20, 0, 1'b1);
        chk("pp_cnt", 32'(fifo_count), 32'd16);
        chk("pp_ovr", 32'(ov_cnt), 32'd1);
        chk("pp_head", 32'(data_out), 32'h01);
        ready = 1'b1;
        clks(25);
        chk("drain_n", 32'(popq.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("drain%0d", i),
                (popq.size() > i) ? 32'(popq[i]) : 32'hDEAD,
                (i < 16) ? 32'(i) : 32'h20);
        end
        chk("drain_cnt", 32'(fifo_count), 32'd0);
        chk("drain_valid", 32'(valid), 32'd0);

        // Reset mid-frame with data stored
        clr();
        ready = 1'b0;
        send(8'h11, 0, 1'b0);
        send(8'h22, 0, 1'b0);
        send(8'h33, 0, 1'b0);
        chk("pre_rst_cnt", 32'(fifo_count), 32'd3);
        rx = 1'b0;
        clks(16);
        rx = 1'b1;
        clks(72);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", 32'(fifo_count), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        clks(3);
        rst = 1'b0;
        clks(20);
        clr();
        ready = 1'b1;
        send(8'h81, 0, 1'b0);
        clks(5);
        chk("post_rst_n", 32'(popq.size()), 32'd1);
        chk("post_rst_data", (popq.size() > 0) ? 32'(popq[0]) : 32'hDEAD,
            32'h81);
        chk("post_rst_fe", 32'(fe_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
